// File: rtl/instr_pkg.sv
// instr_pkg: MIPS instruction kinds, opcode/funct constants and field positions.
// Shared by instr_encoder and the core's control decoder.
package instr_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_JR   = 4'd5,
    K_LW   = 4'd6,
    K_SW   = 4'd7,
    K_BEQ  = 4'd8,
    K_BNE  = 4'd9,
    K_ADDI = 4'd10,
    K_J    = 4'd11,
    K_JAL  = 4'd12
  } kind_e;

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_DONE
  } enc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  function automatic logic [31:0] r_word(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return (32'(OP_RTYPE) << OP_LSB)
         | (32'(rs) << RS_LSB)
         | (32'(rt) << RT_LSB)
         | (32'(rd) << RD_LSB)
         | (32'(5'd0) << SH_LSB)
         | 32'(fn);
  endfunction

  function automatic logic [31:0] i_word(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return (32'(op) << OP_LSB)
         | (32'(rs) << RS_LSB)
         | (32'(rt) << RT_LSB)
         | 32'(imm);
  endfunction

  function automatic logic [31:0] j_word(
    input logic [5:0]  op,
    input logic [25:0] tgt
  );
    return (32'(op) << OP_LSB) | 32'(tgt);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request side and memory-write side of the instruction encoder.
// master drives requests and out_ready; slave is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_word;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_last,
    output out_ready,
    input  in_ready, out_valid, out_addr, out_word, done, err
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_last,
    input  out_ready,
    output in_ready, out_valid, out_addr, out_word, done, err
  );
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO holding {addr, word} entries, with a flush input.
// DEPTH must be a power of two, at least 2.
module instr_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && !clear && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop && !clear && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS words from field requests and streams {addr, word}.
// Define INSTR_ENCODER_BRANCH_REL_EN to treat BEQ/BNE in_imm as an absolute target.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input logic             clk,
  input logic             rst,
  input logic             clear,
  instr_encoder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              enc_valid_q, enc_valid_d;
  logic [ADDR_W-1:0] enc_addr_q, enc_addr_d;
  logic [31:0]       enc_word_q, enc_word_d;

  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty;
  logic [ADDR_W+31:0]   fifo_dout;
  logic                 accept;
  logic                 kind_ok;
  logic [15:0]          br_imm;
  logic [31:0]          word_c;

`ifdef INSTR_ENCODER_BRANCH_REL_EN
  logic [ADDR_W-1:0] br_diff;
  assign br_diff = bus.in_imm[ADDR_W-1:0] - (addr_q + 1'b1);
  assign br_imm  = 16'($signed(br_diff));
`else
  assign br_imm = bus.in_imm[15:0];
`endif

  // Occupancy includes the encode register so an accept can never overflow.
  assign bus.in_ready = (state_q == S_LOAD)
                     && ((fifo_cnt + CW'(enc_valid_q)) < CW'(DEPTH));
  assign accept  = bus.in_valid && bus.in_ready && !clear;
  assign kind_ok = (bus.in_kind <= 4'(K_JAL));

  always_comb begin
    word_c = '0;
    unique case (bus.in_kind)
      K_ADD:   word_c = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_ADD);
      K_SUB:   word_c = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_SUB);
      K_AND:   word_c = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_AND);
      K_OR:    word_c = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_OR);
      K_SLT:   word_c = r_word(bus.in_rs, bus.in_rt, bus.in_rd, FN_SLT);
      // Decoder writes rs+$0 to rd on jr, so rd mirrors rs.
      K_JR:    word_c = r_word(bus.in_rs, 5'd0, bus.in_rs, FN_JR);
      K_LW:    word_c = i_word(OP_LW, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_SW:    word_c = i_word(OP_SW, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_BEQ:   word_c = i_word(OP_BEQ, bus.in_rs, bus.in_rt, br_imm);
      K_BNE:   word_c = i_word(OP_BNE, bus.in_rs, bus.in_rt, br_imm);
      K_ADDI:  word_c = i_word(OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_J:     word_c = j_word(OP_J, bus.in_imm);
      K_JAL:   word_c = j_word(OP_JAL, bus.in_imm);
      default: word_c = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_d       = err_q;
    done_d      = 1'b0;
    enc_valid_d = 1'b0;
    enc_addr_d  = enc_addr_q;
    enc_word_d  = enc_word_q;
    if (clear) begin
      state_d = S_LOAD;
      addr_d  = BASE;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        if (kind_ok) begin
          enc_valid_d = 1'b1;
          enc_addr_d  = addr_q;
          enc_word_d  = word_c;
          addr_d      = addr_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
        if (bus.in_last) state_d = S_DRAIN;
      end
      unique case (state_q)
        S_DRAIN: begin
          if (fifo_empty && !enc_valid_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_LOAD;
          addr_d  = BASE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      addr_q      <= BASE;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_addr_q  <= '0;
      enc_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      done_q      <= done_d;
      enc_valid_q <= enc_valid_d;
      enc_addr_q  <= enc_addr_d;
      enc_word_q  <= enc_word_d;
    end
  end

  instr_fifo #(
    .W     (ADDR_W + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (enc_valid_q),
    .din   ({enc_addr_q, enc_word_q}),
    .pop   (bus.out_valid && bus.out_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_addr  = fifo_dout[ADDR_W+31:32];
  assign bus.out_word  = fifo_dout[31:0];
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written sequences for
// back-pressure, invalid kinds, clear and reset during drain.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic        last;
    logic [9:0]  addr;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [13];
  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [41:0] mon_q [$];

  always @(negedge clk) begin
    if (!rst && !clear && bus.out_valid && bus.out_ready)
      mon_q.push_back({bus.out_addr, bus.out_word});
    if (bus.done) done_cnt++;
  end

  function automatic logic [41:0] mq(input int i);
    if (i < mon_q.size()) return mon_q[i];
    return 'x;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [25:0] imm, input logic last,
                      input int max_cyc, output bit acc);
    bit r;
    bus.in_kind  = k;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    logic ov0, ov1;
    int base, d0;

    tbl[0]  = '{K_ADD,  5'd1,  5'd2,  5'd3, 26'd0,        1'b0, 10'd0,  32'h00221820};
    tbl[1]  = '{K_LW,   5'd29, 5'd8,  5'd0, 26'd4,        1'b0, 10'd1,  32'h8FA80004};
    tbl[2]  = '{K_JAL,  5'd0,  5'd0,  5'd0, 26'h100,      1'b0, 10'd2,  32'h0C000100};
    tbl[3]  = '{K_JR,   5'd31, 5'd5,  5'd7, 26'd0,        1'b0, 10'd3,  32'h03E0F808};
    tbl[4]  = '{K_SUB,  5'd4,  5'd5,  5'd6, 26'd0,        1'b0, 10'd4,  32'h00853022};
`ifdef INSTR_ENCODER_BRANCH_REL_EN
    tbl[5]  = '{K_BEQ,  5'd1,  5'd0,  5'd0, 26'd2,        1'b0, 10'd5,  32'h1020FFFC};
`else
    tbl[5]  = '{K_BEQ,  5'd1,  5'd0,  5'd0, 26'hFFFC,     1'b0, 10'd5,  32'h1020FFFC};
`endif
    tbl[6]  = '{K_AND,  5'd7,  5'd8,  5'd9, 26'd0,        1'b0, 10'd6,  32'h00E84824};
    tbl[7]  = '{K_OR,   5'd10, 5'd11, 5'd12, 26'd0,       1'b0, 10'd7,  32'h014B6025};
    tbl[8]  = '{K_SLT,  5'd13, 5'd14, 5'd15, 26'd0,       1'b0, 10'd8,  32'h01AE782A};
    tbl[9]  = '{K_SW,   5'd29, 5'd31, 5'd0, 26'h8000,     1'b0, 10'd9,  32'hAFBF8000};
`ifdef INSTR_ENCODER_BRANCH_REL_EN
    tbl[10] = '{K_BNE,  5'd2,  5'd3,  5'd9, 26'd27,       1'b0, 10'd10, 32'h14430010};
`else
    tbl[10] = '{K_BNE,  5'd2,  5'd3,  5'd9, 26'h10,       1'b0, 10'd10, 32'h14430010};
`endif
    tbl[11] = '{K_ADDI, 5'd0,  5'd1,  5'd9, 26'h3FFFFFF,  1'b0, 10'd11, 32'h2001FFFF};
    tbl[12] = '{K_J,    5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 1'b1, 10'd12, 32'h0BFFFFFF};

    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_kind = '0;
    bus.in_rs = '0;
    bus.in_rt = '0;
    bus.in_rd = '0;
    bus.in_imm = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_outs", {bus.out_valid, bus.done, bus.err, bus.in_ready},
          {1'b0, 1'b0, 1'b0, 1'b1});
    check("reset_head", {bus.out_addr, bus.out_word}, '0);

    // Table: each vector checks latency, address and encoding.
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm,
           tbl[i].last, 5, acc);
      ov0 = bus.out_valid;
      cycles(1);
      ov1 = bus.out_valid;
      check($sformatf("vec%0d", i),
            {acc, ov0, ov1, bus.out_addr, bus.out_word},
            {1'b1, 1'b0, 1'b1, tbl[i].addr, tbl[i].word});
    end
    cycles(6);
    check("table_done_pulses", done_cnt - d0, 1);

    // Invalid kind between two ADDs.
    base = mon_q.size();
    d0 = done_cnt;
    send(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 5, acc);
    send(4'd14, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0, 5, acc);
    send(K_ADD, 5'd4, 5'd5, 5'd6, 26'd0, 1'b1, 5, acc);
    cycles(8);
    check("inv_count", mon_q.size() - base, 2);
    check("inv_w0", mq(base), {10'd0, 32'h00221820});
    check("inv_w1", mq(base + 1), {10'd1, 32'h00853020});
    check("inv_err", bus.err, 1'b1);
    check("inv_done", done_cnt - d0, 1);
    send(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 5, acc);
    cycles(3);
    check("after_done_addr", mq(base + 2), {10'd0, 32'h00221820});
    check("err_sticky", bus.err, 1'b1);

    // Clear with three queued words and a competing request.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 5, acc);
    bus.in_kind = K_ADD;
    bus.in_valid = 1'b1;
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_outs", {bus.out_valid, bus.err, bus.in_ready},
          {1'b0, 1'b0, 1'b1});
    cycles(1);
    check("clear_no_accept", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    base = mon_q.size();
    send(K_SUB, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, 5, acc);
    cycles(3);
    check("clear_next", mq(base), {10'd0, 32'h00853022});

    clear = 1'b1;
    cycles(1);
    clear = 1'b0;

    // Back-pressure: four fill the FIFO, the fifth is held.
    bus.out_ready = 1'b0;
    base = mon_q.size();
    for (int i = 0; i < 4; i++) begin
      send(K_ADDI, 5'd0, 5'd1, 5'd0, 26'(i), 1'b0, 2, acc);
      check($sformatf("fill%0d", i), acc, 1'b1);
    end
    send(K_ADDI, 5'd0, 5'd1, 5'd0, 26'd4, 1'b0, 4, acc);
    check("fifth_held", {acc, bus.in_ready}, {1'b0, 1'b0});
    check("head_stable", {bus.out_valid, bus.out_addr, bus.out_word},
          {1'b1, 10'd0, 32'h20010000});
    bus.out_ready = 1'b1;
    send(K_ADDI, 5'd0, 5'd1, 5'd0, 26'd4, 1'b0, 10, acc);
    check("fifth_accept", acc, 1'b1);
    cycles(10);
    check("drain_count", mon_q.size() - base, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("drain%0d", i), mq(base + i),
            {10'(i), 32'h20010000 | 32'(i)});

    // Reset during drain loses the word and produces no done.
    bus.out_ready = 1'b0;
    send(K_ADDI, 5'd0, 5'd1, 5'd0, 26'd7, 1'b1, 5, acc);
    base = mon_q.size();
    d0 = done_cnt;
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cycles(8);
    check("rst_drain", {done_cnt - d0, mon_q.size() - base, 31'(bus.out_valid)},
          {32'd0, 32'd0, 31'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles MIPS instruction words from field-level requests and streams them, with their word addresses, to the instruction-memory write port. It produces exactly the encodings the core's control decoder consumes, including the jr convention. It is used by the program loader and by test benches to build programs in instruction memory. Internally it has a registered encode stage, an address counter, an output FIFO and a load/drain/done state machine.

## Interface
- `DEPTH`, 4: output FIFO depth in entries; power of two, ≥2.
- `ADDR_W`, 10: word-address width.
- `BASE_ADDR`, 0: first word address after reset, clear or done.
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush: empties FIFO, rewinds address, clears `err`, returns to LOAD.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted on a cycle where `in_valid && in_ready`.
- `in_kind`  in  4  ADD=0, SUB=1, AND=2, OR=3, SLT=4, JR=5, LW=6, SW=7, BEQ=8, BNE=9, ADDI=10, J=11, JAL=12; 13–15 are invalid.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  26  immediate or jump target; I-type uses bits [15:0].
- `in_last`  in  1  marks the final request of a program.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  memory accepts the head.
- `out_addr`  out  ADDR_W  word address of the head.
- `out_word`  out  32  encoded instruction.
- `done`  out  1  one-cycle pulse: program fully drained.
- `err`  out  1  sticky: an invalid `in_kind` was accepted.

## Operation
- R-type (ADD, SUB, AND, OR, SLT): op 000000, rs, rt, rd, shamt 0, funct 100000 / 100010 / 100100 / 100101 / 101010.
- JR: op 000000, rs=`in_rs`, rt=0, rd=`in_rs`, shamt 0, funct 001000. The decoder writes back rs+$0 into rd on jr, so rd must equal rs.
- I-type: op|rs|rt|imm16. LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000.
- J-type: op|imm26. J 000010, JAL 000011.
- `in_rd` is ignored for I-type and J-type; `in_rs`/`in_rt`/`in_rd` are ignored for J-type.
- Address counter: starts at `BASE_ADDR`. Each valid accepted request takes the current address, then the counter increments, wrapping mod 2^ADDR_W.
- Invalid kind: the request is accepted, nothing is enqueued, the address does not advance, and `err` is set. `in_last` is still honoured.
- FSM:
  - LOAD: `in_ready = !full`. An accepted request with `in_last` moves to DRAIN.
  - DRAIN: `in_ready=0`. Moves to DONE when the FIFO and the encode stage are empty.
  - DONE: `done=1` for this single cycle, the address rewinds to `BASE_ADDR`, then the FSM returns to LOAD.
- Reset values: state LOAD, address `BASE_ADDR`, FIFO empty, `out_valid=0`, `out_addr=0`, `out_word=0`, `done=0`, `err=0`. `in_ready` is 1 in the first cycle after reset.

## Timing
- Latency: a request accepted at edge N sets `out_valid` after edge N+1 (one encode register plus the FIFO write).
- `full` counts the occupied encode stage. `in_ready` is never high when an accepted request could overflow. There is no same-cycle pass-through when full.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- Pop happens on `out_valid && out_ready`. Head outputs hold stable while `out_valid && !out_ready`.
- `clear` overrides an accept or pop in the same cycle and drops all pending words.
- Reset mid-drain: words are lost and no `done` pulse is produced.

## Configuration
- `INSTR_ENCODER_BRANCH_REL_EN` defined: for BEQ/BNE, `in_imm` is an absolute word target. The encoded imm16 is (target − (addr+1)) truncated to 16 bits, with modulo arithmetic at ADDR_W then sign-extended to 16.
- Macro undefined: `in_imm[15:0]` is inserted verbatim for BEQ/BNE.

## Structure
- Package `instr_pkg`: the `in_kind` enum, the opcode and funct constants, and the field bit positions. The package is shared with the control decoder.
- One sub-module, `instr_fifo`: a synchronous FIFO, parameterized by width and depth, storing {addr, word} with `clear`.

## Test plan
- ADD rs=1 rt=2 rd=3 at BASE 0 → `out_word`=0x00221820, `out_addr`=0, `out_valid` one cycle after the accept.
- LW rs=29 rt=8 imm=4, then JAL imm=0x100, then JR rs=31 → 0x8FA80004 @0, 0x0C000100 @1, 0x03E0F808 @2.
- Macro on: BEQ rs=1 rt=0 target=2 at addr 5 → 0x1020FFFC. Macro off with imm=0xFFFC → same word.
- DEPTH=4 with `out_ready=0` and 5 back-to-back requests → 4 accepted, `in_ready` low, 5th held. Raise `out_ready` → 5 words drain in order with addresses 0–4.
- kind=14 between two ADDs, the second with `in_last` → 2 words @0,@1, `err`=1, `done` pulses once after the drain, the next request lands @0.
- Assert `clear` with 3 queued words → `out_valid`=0 the next cycle, `err`=0, the next word @BASE_ADDR.
